// File: rtl/ram_fill_check.sv
// ram_fill_check: fills a RAM window with a (optionally incrementing) pattern, or
// checks a window against it and counts mismatches; 1 word/cycle fill, 2 cycles/word check.
// No backpressure: the RAM is assumed always ready, with read data one cycle after the address.
// Ports: clk/reset (sync, active-high); ctrl_* register slave (0 START, 1 LENGTH,
// 2 PATTERN, 3 CTRL/STATUS); irq level interrupt; m_* RAM master port.
module ram_fill_check #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ctrl_address,
  input  logic              ctrl_write,
  input  logic [31:0]       ctrl_writedata,
  output logic [31:0]       ctrl_readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  output logic              m_clken
);

  typedef enum logic [1:0] {IDLE, FILL, CHK_REQ, CHK_CMP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]    length_q, length_d;
  logic [31:0]         pattern_q, pattern_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    mismatch_q, mismatch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [31:0]         pat_q, pat_d;
  logic                incr_q, incr_d;

  logic busy;
  logic ctrl_wr;
  logic start_req, abort_req, clr_req;
  logic word_done;
  logic unused_wd;

  assign busy      = (state_q != IDLE);
  assign ctrl_wr   = ctrl_write && (ctrl_address == 2'd3);
  assign start_req = ctrl_wr && ctrl_writedata[0];
  assign clr_req   = ctrl_wr && ctrl_writedata[4];
  assign abort_req = ctrl_wr && ctrl_writedata[5];
  assign unused_wd = &{1'b0, ctrl_writedata};

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    length_d   = length_q;
    pattern_d  = pattern_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    mismatch_d = mismatch_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    pat_d      = pat_q;
    incr_d     = incr_q;
    word_done  = 1'b0;

    // Operation parameters are frozen while an operation runs.
    if (ctrl_write && !busy) begin
      case (ctrl_address)
        2'd0:    start_d   = ctrl_writedata[ADDR_W-1:0];
        2'd1:    length_d  = ctrl_writedata[CNT_W-1:0];
        2'd2:    pattern_d = ctrl_writedata;
        default: ;
      endcase
    end

    if (ctrl_wr) irq_en_d = ctrl_writedata[3];
    if (clr_req) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_req && !abort_req) begin
          addr_d     = start_q;
          remain_d   = length_q;
          pat_d      = pattern_q;
          incr_d     = ctrl_writedata[2];
          mismatch_d = '0;
          if (length_q == '0) begin
            // Empty transfer completes immediately without touching the RAM.
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = ctrl_writedata[1] ? CHK_REQ : FILL;
          end
        end
      end
      FILL:    word_done = 1'b1;
      CHK_REQ: state_d = CHK_CMP;
      CHK_CMP: begin
        word_done = 1'b1;
        // Read data for the address issued in CHK_REQ is valid now.
        if ((m_readdata != pat_q) && (mismatch_q != '1))
          mismatch_d = mismatch_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - CNT_W'(1);
      if (incr_q) pat_d = pat_q + 32'd1;
      if (remain_q == CNT_W'(1)) begin
        // Completion takes priority over a same-cycle clear_done.
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (state_q == CHK_CMP) begin
        state_d = CHK_REQ;
      end
    end

    // Abort discards the current word: counters hold and done is not raised.
    if (abort_req && busy) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      addr_d     = addr_q;
      remain_d   = remain_q;
      pat_d      = pat_q;
      mismatch_d = mismatch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= '0;
      length_q   <= '0;
      pattern_q  <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      pat_q      <= '0;
      incr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      length_q   <= length_d;
      pattern_q  <= pattern_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      pat_q      <= pat_d;
      incr_q     <= incr_d;
    end
  end

  always_comb begin
    ctrl_readdata = '0;
    case (ctrl_address)
      2'd0: ctrl_readdata[ADDR_W-1:0] = start_q;
      2'd1: ctrl_readdata[CNT_W-1:0]  = length_q;
      2'd2: ctrl_readdata             = pattern_q;
      default: begin
        ctrl_readdata[0]          = busy;
        ctrl_readdata[1]          = done_q;
        ctrl_readdata[2]          = (mismatch_q != '0);
        ctrl_readdata[3]          = irq_en_q;
        ctrl_readdata[16 +: CNT_W] = mismatch_q;
      end
    endcase
  end

  // Strobes are gated by reset so the RAM sees no access in the reset cycle itself.
  assign m_chipselect = !reset && ((state_q == FILL) || (state_q == CHK_REQ));
  assign m_write      = !reset && (state_q == FILL);
  assign m_address    = addr_q;
  assign m_writedata  = pat_q;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign irq          = !reset && done_q && irq_en_q;

endmodule

// File: tb/tb_ram_fill_check.sv
module tb_ram_fill_check;
  localparam int AW = 11;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    ctrl_address;
  logic          ctrl_write;
  logic [31:0]   ctrl_writedata;
  logic [31:0]   ctrl_readdata;
  logic          irq;
  logic [AW-1:0] m_address;
  logic          m_chipselect;
  logic          m_write;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata;
  logic          m_clken;

  always #5 clk = ~clk;

  ram_fill_check #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ctrl_address(ctrl_address), .ctrl_write(ctrl_write),
    .ctrl_writedata(ctrl_writedata), .ctrl_readdata(ctrl_readdata),
    .irq(irq), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_clken(m_clken)
  );

  // RAM model: synchronous write, registered read (data one cycle after address).
  logic [31:0]   mem [0:2047];
  logic [31:0]   rdq;
  logic          cor_en;
  logic [AW-1:0] cor_a;
  logic [31:0]   cor_d;

  always @(posedge clk) begin
    if (cor_en) mem[cor_a] <= cor_d;
    if (m_chipselect && m_write) mem[m_address] <= m_writedata;
    if (m_chipselect && !m_write) rdq <= mem[m_address];
  end
  assign m_readdata = rdq;

  // Expected bus activity, one entry per busy cycle.
  typedef struct packed {
    logic          cs;
    logic          wr;
    logic [AW-1:0] a;
    logic [31:0]   d;
  } acc_t;

  acc_t     expq[$];
  acc_t     e;
  int       checks = 0;
  int       errors = 0;
  int       busy_cycles = 0;

  // Shadow of programmed registers and expected status.
  logic [AW-1:0] s_start;
  logic [CW-1:0] s_len;
  logic [31:0]   s_pat;
  logic          s_ie;
  logic          s_done;
  int            s_mc;
  logic [31:0]   rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("cs_in_reset", 32'(m_chipselect), 32'd0);
      chk("irq_in_reset", 32'(irq), 32'd0);
    end else begin
      if (ctrl_address == 2'd3) begin
        chk("busy", 32'(ctrl_readdata[0]), 32'(expq.size() != 0));
        if (ctrl_readdata[0]) busy_cycles++;
      end
      chk("byteenable", 32'(m_byteenable), 32'hF);
      chk("clken", 32'(m_clken), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("cs", 32'(m_chipselect), 32'(e.cs));
        chk("wr", 32'(m_write), 32'(e.wr));
        if (e.cs) chk("addr", 32'(m_address), 32'(e.a));
        if (e.cs && e.wr) chk("wdata", m_writedata, e.d);
      end else begin
        chk("cs_idle", 32'(m_chipselect), 32'd0);
        chk("wr_idle", 32'(m_write), 32'd0);
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ctrl_address   = a;
    ctrl_writedata = d;
    ctrl_write     = 1'b1;
    @(posedge clk);
    #1;
    ctrl_write     = 1'b0;
    ctrl_writedata = '0;
    ctrl_address   = 2'd3;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    ctrl_address = a;
    #1;
    d = ctrl_readdata;
    ctrl_address = 2'd3;
  endtask

  task automatic set_regs(input logic [AW-1:0] s, input logic [CW-1:0] l, input logic [31:0] p);
    wr(2'd0, 32'(s));
    wr(2'd1, 32'(l));
    wr(2'd2, p);
    s_start = s;
    s_len   = l;
    s_pat   = p;
  endtask

  task automatic corrupt(input logic [AW-1:0] a, input logic [31:0] d);
    cor_a  = a;
    cor_d  = d;
    cor_en = 1'b1;
    @(posedge clk);
    #1;
    cor_en = 1'b0;
  endtask

  // Start an operation and queue the bus activity it must produce.
  task automatic launch(input logic mode, input logic incr, input logic ie);
    int mc;
    logic [AW-1:0] a;
    logic [31:0]   d;
    mc = 0;
    for (int i = 0; i < int'(s_len); i++) begin
      a = s_start + AW'(i);
      d = s_pat + (incr ? 32'(i) : 32'd0);
      if (mode && (mem[a] != d)) mc++;
    end
    wr(2'd3, {26'd0, 1'b0, 1'b0, ie, incr, mode, 1'b1});
    s_ie = ie;
    for (int i = 0; i < int'(s_len); i++) begin
      a = s_start + AW'(i);
      d = s_pat + (incr ? 32'(i) : 32'd0);
      if (!mode) begin
        expq.push_back({1'b1, 1'b1, a, d});
      end else begin
        expq.push_back({1'b1, 1'b0, a, 32'd0});
        expq.push_back({1'b0, 1'b0, {AW{1'b0}}, 32'd0});
      end
    end
    s_mc   = mc;
    s_done = 1'b1;
  endtask

  task automatic finish_op();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      chk("op_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] status_word(input logic done, input int mc, input logic ie);
    logic [11:0] m12;
    m12 = 12'(mc);
    return {4'd0, m12, 12'd0, ie, (mc != 0), done, 1'b0};
  endfunction

  task automatic check_status(input string name);
    rd(2'd3, rv);
    chk(name, rv, status_word(s_done, s_mc, s_ie));
    chk("irq", 32'(irq), 32'(s_done & s_ie));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset = 1'b1; ctrl_address = 2'd3; ctrl_write = 1'b0; ctrl_writedata = '0;
    cor_en = 1'b0; cor_a = '0; cor_d = '0;
    s_start = '0; s_len = '0; s_pat = '0; s_ie = 1'b0; s_done = 1'b0; s_mc = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), rv);
      chk("reset_reg", rv, 32'd0);
    end
    chk("reset_irq", 32'(irq), 32'd0);

    // Fill 0x010..0x013 with an incrementing pattern.
    set_regs(11'h010, 12'd4, 32'hA5A5_0000);
    launch(1'b0, 1'b1, 1'b1);
    finish_op();
    check_status("fill_status");
    chk("fill_stat_lit", rv, 32'h0000_000A);
    chk("fill_mem0", mem[11'h010], 32'hA5A5_0000);
    chk("fill_mem3", mem[11'h013], 32'hA5A5_0003);

    // Check the same region: 8 busy cycles, no errors, irq raised.
    busy_cycles = 0;
    launch(1'b1, 1'b1, 1'b1);
    finish_op();
    chk("chk_busy_cycles", 32'(busy_cycles), 32'd8);
    check_status("chk_pass_status");
    chk("chk_pass_lit", rv, 32'h0000_000A);
    chk("chk_pass_irq", 32'(irq), 32'd1);

    // Corrupt one word then check.
    corrupt(11'h012, 32'hDEAD_BEEF);
    launch(1'b1, 1'b1, 1'b1);
    finish_op();
    check_status("chk_fail_status");
    chk("chk_fail_lit", rv, 32'h0001_000E);

    // clear_done keeps mismatch count and drops irq.
    wr(2'd3, 32'h0000_0018);
    s_done = 1'b0;
    check_status("clear_done_status");
    chk("clear_done_lit", rv, 32'h0001_000C);

    // Address wrap.
    set_regs(11'h7FE, 12'd4, 32'h1234_0000);
    launch(1'b0, 1'b1, 1'b1);
    finish_op();
    check_status("wrap_status");
    chk("wrap_7fe", mem[11'h7FE], 32'h1234_0000);
    chk("wrap_7ff", mem[11'h7FF], 32'h1234_0001);
    chk("wrap_000", mem[11'h000], 32'h1234_0002);
    chk("wrap_001", mem[11'h001], 32'h1234_0003);

    // Zero length: done without any RAM access.
    set_regs(11'h100, 12'd0, 32'h55);
    launch(1'b0, 1'b0, 1'b1);
    finish_op();
    check_status("len0_status");
    chk("len0_lit", rv, 32'h0000_000A);

    // Register writes and start are ignored while busy.
    set_regs(11'h200, 12'd6, 32'h77);
    launch(1'b0, 1'b0, 1'b1);
    wr(2'd0, 32'h300);
    wr(2'd3, 32'h0000_000B);
    finish_op();
    check_status("busy_ign_status");
    rd(2'd0, rv);
    chk("busy_ign_start", rv, 32'h200);
    chk("busy_ign_mem5", mem[11'h205], 32'h77);

    // Abort after two words.
    set_regs(11'h300, 12'd8, 32'h99);
    launch(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    wr(2'd3, 32'h0000_0028);
    expq.delete();
    s_done = 1'b0;
    s_mc   = 0;
    @(posedge clk);
    #1;
    check_status("abort_status");
    chk("abort_lit", rv, 32'h0000_0008);
    chk("abort_mem1", mem[11'h301], 32'h9A);

    // Randomized operations.
    for (int it = 0; it < 30; it++) begin
      logic          md, inc, ie;
      logic [CW-1:0] len;
      md  = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 24));
      set_regs(11'($urandom), len, $urandom);
      if (md && $urandom_range(0, 1) == 1) begin
        // Mostly-matching region: prefill, then damage a word or two.
        launch(1'b0, inc, ie);
        finish_op();
        if (len != 0) corrupt(s_start + 11'($urandom_range(0, int'(len) - 1)), $urandom);
      end
      launch(md, inc, ie);
      finish_op();
      check_status("rand_status");
      if ($urandom_range(0, 3) == 0) begin
        wr(2'd3, {28'd0, ie, 3'b000} | 32'h10);
        s_done = 1'b0;
        check_status("rand_clear");
      end
    end

    // Reset in the middle of a fill.
    set_regs(11'h400, 12'd20, 32'h1000);
    launch(1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    expq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_cs", 32'(m_chipselect), 32'd0);
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), rv);
      chk("rst_mid_reg", rv, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
